// File: rtl/sprite_eval_if.sv
// OAM read port, secondary buffer write port and control of the
// per-scanline sprite evaluator.
interface sprite_eval_if;
    logic       start;
    logic [7:0] scanline;
    logic [7:0] oam_r_addr;
    logic       oam_r_en;
    logic [7:0] oam_data;
    logic       sec_wr_en;
    logic [4:0] sec_wr_addr;
    logic [7:0] sec_wr_data;
    logic       busy;
    logic       done;
    logic [3:0] sprite_count;
    logic       overflow;

    modport master (
        output start, scanline, oam_data,
        input  oam_r_addr, oam_r_en, sec_wr_en, sec_wr_addr,
        input  sec_wr_data, busy, done, sprite_count, overflow
    );

    modport slave (
        input  start, scanline, oam_data,
        output oam_r_addr, oam_r_en, sec_wr_en, sec_wr_addr,
        output sec_wr_data, busy, done, sprite_count, overflow
    );
endinterface

// File: rtl/sprite_eval.sv
// Scans 64 OAM entries per start and copies sprites covering the
// latched scanline into the secondary buffer, flagging overflow.
module sprite_eval #(
    parameter int NUM_SPRITES   = 64,
    parameter int MAX_PER_LINE  = 8,
    parameter int SPRITE_HEIGHT = 8
) (
    input logic        clk,
    input logic        rst_n,
    sprite_eval_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, FETCH_Y, CHECK_Y, COPY1, COPY2, COPY3, DONE
    } state_t;

    localparam logic [5:0] LAST = 6'(NUM_SPRITES - 1);
    localparam logic [3:0] FULL = 4'(MAX_PER_LINE);

    state_t     state;
    logic [5:0] n;
    logic [7:0] line;
    logic [8:0] diff;
    logic       hit;

    assign diff = {1'b0, line} - {1'b0, bus.oam_data};
    assign hit  = !diff[8] && (diff < 9'(SPRITE_HEIGHT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            n                <= '0;
            line             <= '0;
            bus.oam_r_addr   <= '0;
            bus.oam_r_en     <= 1'b0;
            bus.sec_wr_en    <= 1'b0;
            bus.sec_wr_addr  <= '0;
            bus.sec_wr_data  <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.sprite_count <= '0;
            bus.overflow     <= 1'b0;
        end else begin
            bus.sec_wr_en <= 1'b0;
            bus.done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        line             <= bus.scanline;
                        n                <= '0;
                        bus.sprite_count <= '0;
                        bus.overflow     <= 1'b0;
                        bus.oam_r_addr   <= 8'h00;
                        bus.oam_r_en     <= 1'b1;
                        bus.busy         <= 1'b1;
                        state            <= FETCH_Y;
                    end
                end
                FETCH_Y: begin
                    // byte1 is requested speculatively so a hit needs no bubble
                    bus.oam_r_addr <= {n, 2'b01};
                    state          <= CHECK_Y;
                end
                CHECK_Y: begin
                    if (hit && bus.sprite_count < FULL) begin
                        bus.sec_wr_en   <= 1'b1;
                        bus.sec_wr_addr <= {bus.sprite_count[2:0], 2'b00};
                        bus.sec_wr_data <= bus.oam_data;
                        bus.oam_r_addr  <= {n, 2'b10};
                        state           <= COPY1;
                    end else if (hit || n == LAST) begin
                        bus.overflow   <= hit;
                        bus.oam_r_en   <= 1'b0;
                        bus.oam_r_addr <= '0;
                        bus.done       <= 1'b1;
                        state          <= DONE;
                    end else begin
                        n              <= n + 6'd1;
                        bus.oam_r_addr <= {n + 6'd1, 2'b00};
                        state          <= FETCH_Y;
                    end
                end
                COPY1: begin
                    bus.sec_wr_en   <= 1'b1;
                    bus.sec_wr_addr <= {bus.sprite_count[2:0], 2'b01};
                    bus.sec_wr_data <= bus.oam_data;
                    bus.oam_r_addr  <= {n, 2'b11};
                    state           <= COPY2;
                end
                COPY2: begin
                    bus.sec_wr_en   <= 1'b1;
                    bus.sec_wr_addr <= {bus.sprite_count[2:0], 2'b10};
                    bus.sec_wr_data <= bus.oam_data;
                    bus.oam_r_en    <= 1'b0;
                    bus.oam_r_addr  <= '0;
                    state           <= COPY3;
                end
                COPY3: begin
                    bus.sec_wr_en    <= 1'b1;
                    bus.sec_wr_addr  <= {bus.sprite_count[2:0], 2'b11};
                    bus.sec_wr_data  <= bus.oam_data;
                    bus.sprite_count <= bus.sprite_count + 4'd1;
                    if (n == LAST) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        n              <= n + 6'd1;
                        bus.oam_r_addr <= {n + 6'd1, 2'b00};
                        bus.oam_r_en   <= 1'b1;
                        state          <= FETCH_Y;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_eval.sv
// Directed bench for sprite_eval: OAM model, secondary buffer
// monitor, timing and content checks per scenario.
module tb_sprite_eval;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] oam [256];
    logic [7:0] sec [32];
    int         wr_cnt;

    sprite_eval_if ifa ();
    sprite_eval_if ifb ();

    sprite_eval #(.SPRITE_HEIGHT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );
    sprite_eval #(.SPRITE_HEIGHT(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifa.oam_r_en) ifa.oam_data <= oam[ifa.oam_r_addr];
        if (ifb.oam_r_en) ifb.oam_data <= oam[ifb.oam_r_addr];
    end

    always @(negedge clk) begin
        if (ifa.sec_wr_en) begin
            sec[ifa.sec_wr_addr] = ifa.sec_wr_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic clear_oam();
        for (int i = 0; i < 256; i++) oam[i] = (i % 4 == 0) ? 8'hFF : 8'h00;
        for (int i = 0; i < 32; i++) sec[i] = 8'h00;
    endtask

    task automatic put(input int s, input int y, input int t, input int a, input int x);
        oam[s*4]   = 8'(y);
        oam[s*4+1] = 8'(t);
        oam[s*4+2] = 8'(a);
        oam[s*4+3] = 8'(x);
    endtask

    function automatic logic dn(input bit sel);
        return sel ? ifb.done : ifa.done;
    endfunction

    task automatic run_scan(input bit sel, input logic [7:0] line,
                            input int inject, output int cyc);
        wr_cnt = 0;
        @(negedge clk);
        if (sel) begin ifb.start = 1'b1; ifb.scanline = line; end
        else begin ifa.start = 1'b1; ifa.scanline = line; end
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        cyc = 1;
        while (!dn(sel) && cyc < 400) begin
            if (cyc == inject) begin
                ifa.start = 1'b1;
                ifa.scanline = 8'd200;
            end
            @(negedge clk);
            ifa.start = 1'b0;
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({ifa.oam_r_addr, ifa.oam_r_en, ifa.sec_wr_en, ifa.busy,
             ifa.done, ifa.sprite_count, ifa.overflow} !== 17'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", {ifa.oam_r_addr,
                ifa.oam_r_en, ifa.sec_wr_en, ifa.busy, ifa.done,
                ifa.sprite_count, ifa.overflow});
        end
    endtask

    task automatic test_reset_midscan();
        int cyc;
        clear_oam();
        put(0, 50, 1, 2, 3);
        @(negedge clk);
        ifa.start = 1'b1;
        ifa.scanline = 8'd50;
        @(negedge clk);
        ifa.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ifa.busy !== 1'b1 || ifa.oam_r_en !== 1'b1) begin
            errors++;
            $display("FAIL midscan_busy: busy=%b en=%b want 1 1", ifa.busy, ifa.oam_r_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifa.oam_r_addr, ifa.oam_r_en, ifa.sec_wr_en, ifa.busy,
             ifa.done, ifa.sprite_count, ifa.overflow} !== 17'd0) begin
            errors++;
            $display("FAIL reset_midscan: outputs not all zero");
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(1'b0, 8'd50, -1, cyc);
        checks++;
        if (cyc !== 132 || ifa.sprite_count !== 4'd1 || wr_cnt !== 4) begin
            errors++;
            $display("FAIL after_reset: cyc=%0d cnt=%0d wr=%0d want 132 1 4",
                     cyc, ifa.sprite_count, wr_cnt);
        end
        checks++;
        if ({sec[0], sec[1], sec[2], sec[3]} !== 32'h32010203) begin
            errors++;
            $display("FAIL after_reset_slot: got %h want 32010203",
                     {sec[0], sec[1], sec[2], sec[3]});
        end
    endtask

    task automatic test_no_hits();
        int cyc;
        clear_oam();
        run_scan(1'b0, 8'd10, -1, cyc);
        checks++;
        if (cyc !== 129 || ifa.sprite_count !== 4'd0 ||
            ifa.overflow !== 1'b0 || wr_cnt !== 0) begin
            errors++;
            $display("FAIL no_hits: cyc=%0d cnt=%0d ovf=%b wr=%0d want 129 0 0 0",
                     cyc, ifa.sprite_count, ifa.overflow, wr_cnt);
        end
    endtask

    task automatic check_three(input string name, input int cyc);
        checks++;
        if (cyc !== 138 || ifa.sprite_count !== 4'd3 || wr_cnt !== 12) begin
            errors++;
            $display("FAIL %s_timing: cyc=%0d cnt=%0d wr=%0d want 138 3 12",
                     name, cyc, ifa.sprite_count, wr_cnt);
        end
        checks++;
        if ({sec[0], sec[1], sec[2], sec[3]} !== 32'h0A05450A) begin
            errors++;
            $display("FAIL %s_slot0: got %h want 0a05450a", name,
                     {sec[0], sec[1], sec[2], sec[3]});
        end
        checks++;
        if ({sec[4], sec[5], sec[6], sec[7]} !== 32'h0A145428) begin
            errors++;
            $display("FAIL %s_slot1: got %h want 0a145428", name,
                     {sec[4], sec[5], sec[6], sec[7]});
        end
        checks++;
        if ({sec[8], sec[9], sec[10], sec[11]} !== 32'h0A3F7F7E) begin
            errors++;
            $display("FAIL %s_slot2: got %h want 0a3f7f7e", name,
                     {sec[8], sec[9], sec[10], sec[11]});
        end
    endtask

    task automatic setup_three();
        clear_oam();
        put(5, 10, 5, 8'h45, 10);
        put(20, 10, 20, 8'h54, 40);
        put(63, 10, 63, 8'h7F, 126);
    endtask

    task automatic test_three_hits();
        int cyc;
        setup_three();
        run_scan(1'b0, 8'd12, -1, cyc);
        check_three("three", cyc);
    endtask

    task automatic test_overflow();
        int cyc;
        clear_oam();
        for (int s = 0; s < 9; s++) put(s, 50, s, 8'h40 + s, 3 * s);
        run_scan(1'b0, 8'd50, -1, cyc);
        checks++;
        if (cyc !== 43 || ifa.sprite_count !== 4'd8 ||
            ifa.overflow !== 1'b1 || wr_cnt !== 32) begin
            errors++;
            $display("FAIL overflow: cyc=%0d cnt=%0d ovf=%b wr=%0d want 43 8 1 32",
                     cyc, ifa.sprite_count, ifa.overflow, wr_cnt);
        end
        checks++;
        if ({sec[28], sec[29], sec[30], sec[31]} !== 32'h32074715) begin
            errors++;
            $display("FAIL overflow_slot7: got %h want 32074715",
                     {sec[28], sec[29], sec[30], sec[31]});
        end
    endtask

    task automatic test_boundaries();
        int cyc;
        logic [7:0] lines [4];
        logic [3:0] want [4];
        lines = '{8'd100, 8'd107, 8'd108, 8'd99};
        want  = '{4'd1, 4'd1, 4'd0, 4'd0};
        clear_oam();
        put(0, 100, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_scan(1'b0, lines[i], -1, cyc);
            checks++;
            if (ifa.sprite_count !== want[i]) begin
                errors++;
                $display("FAIL bound_line%0d: cnt=%0d want %0d",
                         lines[i], ifa.sprite_count, want[i]);
            end
        end
        run_scan(1'b1, 8'd115, -1, cyc);
        checks++;
        if (ifb.sprite_count !== 4'd1 || cyc !== 132) begin
            errors++;
            $display("FAIL bound_h16_115: cnt=%0d cyc=%0d want 1 132",
                     ifb.sprite_count, cyc);
        end
        run_scan(1'b1, 8'd116, -1, cyc);
        checks++;
        if (ifb.sprite_count !== 4'd0) begin
            errors++;
            $display("FAIL bound_h16_116: cnt=%0d want 0", ifb.sprite_count);
        end
        put(0, 8'hFC, 0, 0, 0);
        run_scan(1'b0, 8'd2, -1, cyc);
        checks++;
        if (ifa.sprite_count !== 4'd0 || wr_cnt !== 0) begin
            errors++;
            $display("FAIL bound_wrap: cnt=%0d wr=%0d want 0 0",
                     ifa.sprite_count, wr_cnt);
        end
    endtask

    task automatic test_start_busy();
        int cyc;
        setup_three();
        run_scan(1'b0, 8'd12, 40, cyc);
        check_three("busy_start", cyc);
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle: busy=%b want 0", ifa.busy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.start = 1'b0;
        ifa.scanline = 8'd0;
        ifb.start = 1'b0;
        ifb.scanline = 8'd0;
        clear_oam();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_no_hits();
        test_three_hits();
        test_overflow();
        test_boundaries();
        test_start_busy();
        test_reset_midscan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
